// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: round-robin grant, latched downstream request,
// per-requester captured read data/response and a one-cycle done pulse.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // requester 0: instruction fetch
  input  logic                    m0_req_i,
  input  logic                    m0_wen_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [2:0]              m0_size_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wmask_i,
  output logic                    m0_done_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  output logic [1:0]              m0_resp_o,
  // requester 1: load/store
  input  logic                    m1_req_i,
  input  logic                    m1_wen_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [2:0]              m1_size_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wmask_i,
  output logic                    m1_done_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic [1:0]              m1_resp_o,
  // downstream port
  output logic                    rw_cen_o,
  output logic                    rw_wen_o,
  output logic [ADDR_WIDTH-1:0]   rw_addr_o,
  output logic [2:0]              rw_size_o,
  output logic [DATA_WIDTH-1:0]   rw_wdata_o,
  output logic [DATA_WIDTH/8-1:0] rw_wmask_o,
  input  logic                    rw_ready_i,
  input  logic [DATA_WIDTH-1:0]   rw_rdata_i,
  input  logic                    rw_rvalid_i,
  input  logic [1:0]              rw_resp_i,
  // FSM state for observation
  output logic [1:0]              dbg_state_o
);

  // Handshake: a requester raises mN_req_i with stable fields and holds them until the
  // cycle mN_done_o is high; downstream sees rw_cen_o held for the whole transaction and
  // ends it with a single-cycle rw_ready_i (rw_rvalid_i qualifies rw_rdata_i).

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                    sel_q;
  logic                    last_q;
  logic                    win;
  logic                    any_req;
  logic                    wen_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              size_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wmask_q;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata1_q;
  logic [1:0]              resp0_q, resp1_q;

  assign any_req = m0_req_i | m1_req_i;
  // On a tie the requester not granted last wins; otherwise the lone requester wins.
  assign win = (m0_req_i & m1_req_i) ? ~last_q : m1_req_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    rw_cen_o  = 1'b0;
    m0_done_o = 1'b0;
    m1_done_o = 1'b0;
    unique case (state_q)
      IDLE: if (any_req) state_d = BUSY;
      BUSY: begin
        rw_cen_o = 1'b1;
        if (rw_ready_i) state_d = GAP;
      end
      GAP: begin
        m0_done_o = ~sel_q;
        m1_done_o = sel_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (state_q == IDLE && any_req) begin
      sel_q   <= win;
      last_q  <= win;
      wen_q   <= win ? m1_wen_i   : m0_wen_i;
      addr_q  <= win ? m1_addr_i  : m0_addr_i;
      size_q  <= win ? m1_size_i  : m0_size_i;
      wdata_q <= win ? m1_wdata_i : m0_wdata_i;
      wmask_q <= win ? m1_wmask_i : m0_wmask_i;
    end
  end

  // Downstream completion is only honoured while a transaction is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
      resp0_q  <= '0;
      resp1_q  <= '0;
    end else if (state_q == BUSY) begin
      if (rw_rvalid_i) begin
        if (sel_q) rdata1_q <= rw_rdata_i;
        else       rdata0_q <= rw_rdata_i;
      end
      if (rw_ready_i) begin
        if (sel_q) resp1_q <= rw_resp_i;
        else       resp0_q <= rw_resp_i;
      end
    end
  end

  assign rw_wen_o    = wen_q;
  assign rw_addr_o   = addr_q;
  assign rw_size_o   = size_q;
  assign rw_wdata_o  = wdata_q;
  assign rw_wmask_o  = wmask_q;
  assign m0_rdata_o  = rdata0_q;
  assign m1_rdata_o  = rdata1_q;
  assign m0_resp_o   = resp0_q;
  assign m1_resp_o   = resp1_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: requester drivers, a downstream responder
// model and a done-ordered scoreboard.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int DW = 64;
  localparam int AW = 64;
  localparam int MW = DW / 8;

  typedef struct packed {
    logic          id;
    logic          wen;
    logic [AW-1:0] addr;
    logic [2:0]    size;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          m0_req_i, m0_wen_i, m1_req_i, m1_wen_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [2:0]    m0_size_i, m1_size_i;
  logic [DW-1:0] m0_wdata_i, m1_wdata_i;
  logic [MW-1:0] m0_wmask_i, m1_wmask_i;
  logic          m0_done_o, m1_done_o;
  logic [DW-1:0] m0_rdata_o, m1_rdata_o;
  logic [1:0]    m0_resp_o, m1_resp_o;
  logic          rw_cen_o, rw_wen_o;
  logic [AW-1:0] rw_addr_o;
  logic [2:0]    rw_size_o;
  logic [DW-1:0] rw_wdata_o;
  logic [MW-1:0] rw_wmask_o;
  logic          rw_ready_i, rw_rvalid_i;
  logic [DW-1:0] rw_rdata_i;
  logic [1:0]    rw_resp_i;
  logic [1:0]    dbg_state_o;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_wen_i(m0_wen_i), .m0_addr_i(m0_addr_i), .m0_size_i(m0_size_i),
    .m0_wdata_i(m0_wdata_i), .m0_wmask_i(m0_wmask_i), .m0_done_o(m0_done_o),
    .m0_rdata_o(m0_rdata_o), .m0_resp_o(m0_resp_o),
    .m1_req_i(m1_req_i), .m1_wen_i(m1_wen_i), .m1_addr_i(m1_addr_i), .m1_size_i(m1_size_i),
    .m1_wdata_i(m1_wdata_i), .m1_wmask_i(m1_wmask_i), .m1_done_o(m1_done_o),
    .m1_rdata_o(m1_rdata_o), .m1_resp_o(m1_resp_o),
    .rw_cen_o(rw_cen_o), .rw_wen_o(rw_wen_o), .rw_addr_o(rw_addr_o), .rw_size_o(rw_size_o),
    .rw_wdata_o(rw_wdata_o), .rw_wmask_o(rw_wmask_o), .rw_ready_i(rw_ready_i),
    .rw_rdata_i(rw_rdata_i), .rw_rvalid_i(rw_rvalid_i), .rw_resp_i(rw_resp_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  exp_t          exp_q[$];
  logic [DW-1:0] push_rd[2];
  int            checks = 0;
  int            errors = 0;
  logic          spur = 1'b0;
  int            dn_cur_lat = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Downstream data and response derived from the address.
  function automatic logic [DW-1:0] dn_rdata(input logic [AW-1:0] a);
    if (a == 64'h8000_0000) return 64'h1122_3344_5566_7788;
    return {~a[31:0], a[31:0]};
  endfunction

  function automatic logic [1:0] dn_resp(input logic [AW-1:0] a);
    return a[5:4] ^ {a[12], a[3]};
  endfunction

  task automatic push_exp(input logic id, input logic wen, input logic [AW-1:0] addr,
                          input logic [2:0] size, input logic [DW-1:0] wdata,
                          input logic [MW-1:0] wmask);
    exp_t e;
    e.id    = id;
    e.wen   = wen;
    e.addr  = addr;
    e.size  = size;
    e.wdata = wdata;
    e.wmask = wmask;
    e.rdata = wen ? push_rd[id] : dn_rdata(addr);
    e.resp  = dn_resp(addr);
    push_rd[id] = e.rdata;
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_req(input logic id, input logic wen, input logic [AW-1:0] addr,
                           input logic [2:0] size, input logic [DW-1:0] wdata,
                           input logic [MW-1:0] wmask);
    if (id) begin
      m1_req_i = 1'b1; m1_wen_i = wen; m1_addr_i = addr;
      m1_size_i = size; m1_wdata_i = wdata; m1_wmask_i = wmask;
    end else begin
      m0_req_i = 1'b1; m0_wen_i = wen; m0_addr_i = addr;
      m0_size_i = size; m0_wdata_i = wdata; m0_wmask_i = wmask;
    end
  endtask

  task automatic wait_done(input logic id);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      n++;
      seen = id ? m1_done_o : m0_done_o;
    end
    chk(id ? "m1_done_seen" : "m0_done_seen", 64'(seen), 64'(1));
    if (id) m1_req_i = 1'b0;
    else    m0_req_i = 1'b0;
  endtask

  task automatic txn(input logic id, input logic wen, input logic [AW-1:0] addr,
                     input logic [2:0] size, input logic [DW-1:0] wdata,
                     input logic [MW-1:0] wmask);
    @(negedge clk);
    push_exp(id, wen, addr, size, wdata, wmask);
    start_req(id, wen, addr, size, wdata, wmask);
    wait_done(id);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    push_rd[0] = '0;
    push_rd[1] = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- downstream responder ----------------
  initial begin
    int dn_cnt = 0;
    rw_ready_i = 1'b0; rw_rvalid_i = 1'b0; rw_rdata_i = '0; rw_resp_i = '0;
    forever begin
      @(negedge clk);
      rw_ready_i  = 1'b0;
      rw_rvalid_i = 1'b0;
      if (spur) begin
        rw_ready_i  = 1'b1;
        rw_rvalid_i = 1'b1;
        rw_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
        rw_resp_i   = 2'b11;
      end else if (rst_n && rw_cen_o) begin
        dn_cnt++;
        if (dn_cnt == 1)
          dn_cur_lat = (rw_addr_o == 64'h8000_0000) ? 3 : int'($urandom_range(1, 4));
        if (dn_cnt == dn_cur_lat) begin
          rw_ready_i  = 1'b1;
          rw_rvalid_i = !rw_wen_o;
          rw_rdata_i  = dn_rdata(rw_addr_o);
          rw_resp_i   = dn_resp(rw_addr_o);
          dn_cnt      = 0;
        end
      end else begin
        dn_cnt = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int            cen_cnt = 0;
    logic [DW-1:0] mdl_rd[2];
    logic [1:0]    mdl_rs[2];
    exp_t          e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cen_cnt = 0;
        mdl_rd[0] = '0; mdl_rd[1] = '0;
        mdl_rs[0] = '0; mdl_rs[1] = '0;
      end else begin
        if (rw_cen_o) begin
          cen_cnt++;
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("rw_addr",  rw_addr_o,         e.addr);
            chk("rw_wen",   64'(rw_wen_o),     64'(e.wen));
            chk("rw_size",  64'(rw_size_o),    64'(e.size));
            chk("rw_wdata", rw_wdata_o,        e.wdata);
            chk("rw_wmask", 64'(rw_wmask_o),   64'(e.wmask));
          end
        end else if (cen_cnt != 0) begin
          chk("busy_len", 64'(cen_cnt), 64'(dn_cur_lat));
          cen_cnt = 0;
        end
        if (m0_done_o || m1_done_o) begin
          chk("done_one_hot", 64'(m0_done_o & m1_done_o), 64'(0));
          chk("done_cen_low", 64'(rw_cen_o), 64'(0));
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("done_id", 64'(m1_done_o), 64'(e.id));
            mdl_rd[e.id] = e.rdata;
            mdl_rs[e.id] = e.resp;
          end
          chk("m0_rdata", m0_rdata_o,      mdl_rd[0]);
          chk("m1_rdata", m1_rdata_o,      mdl_rd[1]);
          chk("m0_resp",  64'(m0_resp_o),  64'(mdl_rs[0]));
          chk("m1_resp",  64'(m1_resp_o),  64'(mdl_rs[1]));
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] m1_wd[4];
    logic [MW-1:0] m1_wm[4];
    m0_req_i = 0; m0_wen_i = 0; m0_addr_i = '0; m0_size_i = '0; m0_wdata_i = '0; m0_wmask_i = '0;
    m1_req_i = 0; m1_wen_i = 0; m1_addr_i = '0; m1_size_i = '0; m1_wdata_i = '0; m1_wmask_i = '0;
    push_rd[0] = '0;
    push_rd[1] = '0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_cen",    64'(rw_cen_o),    64'(0));
    chk("rst_wen",    64'(rw_wen_o),    64'(0));
    chk("rst_done0",  64'(m0_done_o),   64'(0));
    chk("rst_done1",  64'(m1_done_o),   64'(0));
    chk("rst_addr",   rw_addr_o,        64'(0));
    chk("rst_rdata0", m0_rdata_o,       64'(0));
    chk("rst_resp1",  64'(m1_resp_o),   64'(0));
    chk("rst_state",  64'(dbg_state_o), 64'(0));
    rst_n = 1'b1;

    // single read, then single write
    txn(1'b0, 1'b0, 64'h8000_0000, 3'd3, '0, '0);
    txn(1'b1, 1'b1, 64'h1000, 3'd2, 64'hDEAD_BEEF, 8'h0F);

    // spurious completion while idle
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("spur_state", 64'(dbg_state_o), 64'(0));
      chk("spur_done",  64'({m0_done_o, m1_done_o}), 64'(0));
      chk("spur_rdata0", m0_rdata_o, 64'h1122_3344_5566_7788);
      chk("spur_resp1",  64'(m1_resp_o), 64'(dn_resp(64'h1000)));
    end

    // simultaneous requests out of reset: m0 then m1
    do_reset();
    @(negedge clk);
    push_exp(1'b0, 1'b0, 64'h40, 3'd3, '0, '0);
    push_exp(1'b1, 1'b0, 64'h3008, 3'd3, '0, '0);
    start_req(1'b0, 1'b0, 64'h40, 3'd3, '0, '0);
    start_req(1'b1, 1'b0, 64'h3008, 3'd3, '0, '0);
    fork
      wait_done(1'b0);
      wait_done(1'b1);
    join

    // continuous re-requests alternate m0, m1, ...
    for (int k = 0; k < 4; k++) begin
      m1_wd[k] = {$urandom, $urandom};
      m1_wm[k] = MW'($urandom_range(1, 255));
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      push_exp(1'b0, 1'b0, 64'h100 + 64'(k * 16), 3'd3, '0, '0);
      push_exp(1'b1, 1'(k), 64'h2000 + 64'(k * 24), 3'd3, m1_wd[k], m1_wm[k]);
    end
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          start_req(1'b0, 1'b0, 64'h100 + 64'(i * 16), 3'd3, '0, '0);
          wait_done(1'b0);
        end
      end
      begin
        for (int j = 0; j < 4; j++) begin
          start_req(1'b1, 1'(j), 64'h2000 + 64'(j * 24), 3'd3, m1_wd[j], m1_wm[j]);
          wait_done(1'b1);
        end
      end
    join

    // reset two cycles into BUSY abandons m0; pending m1 is served afterwards
    do_reset();
    @(negedge clk);
    start_req(1'b0, 1'b0, 64'h8000_0000, 3'd3, '0, '0);
    start_req(1'b1, 1'b0, 64'h5010, 3'd3, '0, '0);
    repeat (2) @(negedge clk);
    chk("pre_abort_cen", 64'(rw_cen_o), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cen",    64'(rw_cen_o),    64'(0));
    chk("abort_wen",    64'(rw_wen_o),    64'(0));
    chk("abort_addr",   rw_addr_o,        64'(0));
    chk("abort_done",   64'({m0_done_o, m1_done_o}), 64'(0));
    chk("abort_rdata0", m0_rdata_o,       64'(0));
    chk("abort_state",  64'(dbg_state_o), 64'(0));
    m0_req_i = 1'b0;
    push_rd[0] = '0;
    push_rd[1] = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_exp(1'b1, 1'b0, 64'h5010, 3'd3, '0, '0);
    rst_n = 1'b1;
    wait_done(1'b1);

    repeat (4) @(negedge clk);
    chk("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the width of data on all ports.
REQ-002 Parameter ADDR_WIDTH, default 64, SHALL set the width of addresses on all ports.
REQ-003 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 mN_req_i  input  1  SHALL be the requester N request, N = 0 (instruction fetch) or 1 (load/store).
REQ-006 mN_wen_i  input  1  SHALL select write (1) or read (0).
REQ-007 mN_addr_i  input  ADDR_WIDTH  SHALL be the request address.
REQ-008 mN_size_i  input  3  SHALL be the AXI-encoded access size.
REQ-009 mN_wdata_i  input  DATA_WIDTH  SHALL be the write data.
REQ-010 mN_wmask_i  input  DATA_WIDTH/8  SHALL be the byte strobes.
REQ-011 mN_done_o  output  1  SHALL be a one-cycle completion pulse.
REQ-012 mN_rdata_o  output  DATA_WIDTH  SHALL be the captured read data.
REQ-013 mN_resp_o  output  2  SHALL be the captured response.
REQ-014 rw_cen_o  output  1  SHALL be the downstream request.
REQ-015 rw_wen_o  output  1  SHALL be the downstream write select.
REQ-016 rw_addr_o  output  ADDR_WIDTH  SHALL be the downstream address.
REQ-017 rw_size_o  output  3  SHALL be the downstream size.
REQ-018 rw_wdata_o  output  DATA_WIDTH  SHALL be the downstream write data.
REQ-019 rw_wmask_o  output  DATA_WIDTH/8  SHALL be the downstream byte strobes.
REQ-020 rw_ready_i  input  1  SHALL be a one-cycle pulse marking downstream transaction done.
REQ-021 rw_rdata_i  input  DATA_WIDTH  SHALL be the downstream read data.
REQ-022 rw_rvalid_i  input  1  SHALL qualify rw_rdata_i.
REQ-023 rw_resp_i  input  2  SHALL be the downstream response.

Function
REQ-024 The state machine SHALL have states IDLE, BUSY and GAP, with one encoded state register.
REQ-025 In IDLE with any mN_req_i high, the block SHALL, at the next edge, latch the winner index plus its wen/addr/size/wdata/wmask into registers and go to BUSY.
REQ-026 Arbitration SHALL be round-robin: a lone requester wins; if both request, the one not granted last wins; the last-granted pointer resets to 1, so m0 wins the first tie.
REQ-027 rw_cen_o SHALL be high exactly while in BUSY (registered, no combinational path from mN_req_i).
REQ-028 rw_* fields SHALL be driven only from the latched registers and SHALL stay stable for the whole of BUSY.
REQ-029 In BUSY, each cycle with rw_rvalid_i high SHALL capture rw_rdata_i into the winner's mN_rdata_o register.
REQ-030 In BUSY, rw_ready_i high SHALL capture rw_resp_i into the winner's mN_resp_o and move the state to GAP.
REQ-031 In GAP, mN_done_o of the winner SHALL be high for exactly one cycle, rw_cen_o SHALL be low, and the next state SHALL be IDLE unconditionally.
REQ-032 The one-cycle low gap on rw_cen_o SHALL occur between every pair of consecutive transactions.
REQ-033 Minimum latency SHALL be: req sampled at edge 0, rw_cen_o high from cycle 1, and mN_done_o in the cycle after rw_ready_i.
REQ-034 Requester protocol: mN_req_i and its fields SHALL be held until mN_done_o; the requester SHALL drop req, or present a new request, at the edge ending the done cycle.
REQ-035 A requester's mN_req_i SHALL be ignored while the block is in BUSY or GAP; the non-winning requester SHALL wait, and no request SHALL be lost.
REQ-036 mN_rdata_o and mN_resp_o SHALL hold their last captured value until overwritten by a later transaction to the same requester.
REQ-037 rw_rvalid_i or rw_ready_i seen outside BUSY SHALL be ignored.
REQ-038 At most one mN_done_o SHALL be high in any cycle.

Reset
REQ-039 While rst_n is low: state SHALL be IDLE; rw_cen_o, rw_wen_o and mN_done_o SHALL be 0; all latched fields, mN_rdata_o and mN_resp_o SHALL be 0; the last-granted pointer SHALL be 1.
REQ-040 Reset asserted mid-BUSY SHALL abandon the transaction: no mN_done_o is issued, and after release the block SHALL re-arbitrate from IDLE.

Verification
REQ-041 Single read: m0 reads addr 0x8000_0000, size 3; downstream returns rvalid + ready with data 0x1122334455667788 three cycles after cen -> rw_cen_o high for 3 cycles, m0_done_o one cycle later, m0_rdata_o = 0x1122334455667788.
REQ-042 Single write: m1 writes addr 0x1000, data 0xDEADBEEF, wmask 0x0F -> rw_wen_o = 1 and fields stable throughout BUSY; m1_done_o after ready; m1_resp_o = rw_resp_i.
REQ-043 Simultaneous requests out of reset -> m0 served first; gap cycle with rw_cen_o = 0; then m1 served; both done pulses seen, order m0, m1.
REQ-044 Both requesters continuously re-request 4 times -> grants alternate m0, m1, m0, m1, ...; no starvation.
REQ-045 Reset asserted two cycles into BUSY -> all outputs return to 0 immediately; no done pulse; after release, a pending m1 request is granted normally.
REQ-046 Spurious rw_ready_i pulse in IDLE -> no state change, no done pulse, captured data unchanged.
